logic_unit_pipe: RTL and testbench

//  Pipelined bitwise logic unit for Int_ALU. It is the responder side of the gate-level operand

---
 rtl/logic_unit_pipe.sv | 141 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides.
// Stage 1 captures operands; stage 2 registers the result, opcode, zero flag and counts consumed results.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_o,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NOR  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTX = 3'b110,
    OP_PASY = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [OP_W-1:0]  op;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] o;
    logic [OP_W-1:0]  op;
    logic             zero;
  } s2_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             advance1;
  logic             advance2;
  logic [WIDTH-1:0] result;

  // Pure bitwise function; no carries, result width equals operand width.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_XNOR: r = ~(x ^ y);
      OP_NOTX: r = ~x;
      OP_PASY: r = y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage 2 may move whenever its slot is empty or being drained; stage 1 chains behind it.
  always_comb begin
    advance2 = !out_valid_q || out_ready;
    advance1 = !s1_valid_q || advance2;
  end

  always_comb begin
    result = logic_op(s1_q.op, s1_q.x, s1_q.y);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    s2_d        = s2_q;
    op_count_d  = op_count_q;

    if (advance1) begin
      s1_valid_d = in_valid;
      s1_d.x     = in_x;
      s1_d.y     = in_y;
      s1_d.op    = in_op;
    end

    // Output payload only changes when a real result moves in, so it stays stable otherwise.
    if (advance2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.o    = result;
        s2_d.op   = s1_q.op;
        s2_d.zero = (result == '0);
      end
    end

    if (out_valid_q && out_ready) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      s2_q        <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      s2_q        <= s2_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = advance1;
  assign out_valid = out_valid_q;
  assign out_o     = s2_q.o;
  assign out_op    = s2_q.op;
  assign out_zero  = s2_q.zero;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes hand-computed results, a negedge monitor pops and compares.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_o;
  logic [2:0]       out_op;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_o(out_o), .out_op(out_op), .out_zero(out_zero),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] o;
    logic [2:0] op;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid && ready is seen here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got o=%b op=%b, expected no output", out_o, out_op);
      end else begin
        e = sb_q.pop_front();
        check("out_o",    32'(out_o),    32'(e.o));
        check("out_op",   32'(out_op),   32'(e.op));
        check("out_zero", 32'(out_zero), 32'(e.o == 4'b0000));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic try_send(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op,
                          input logic [3:0] exp_o, input int max_cyc, output bit acc);
    logic rdy;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_op    = op;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc = 1'b1;
    end
    if (acc) sb_q.push_back('{o: exp_o, op: op});
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op,
                      input logic [3:0] exp_o);
    bit acc;
    try_send(x, y, op, exp_o, 20, acc);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, expected acceptance");
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_drain(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int first_pops;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_op_count",  32'(op_count),  32'd0);
    check("rst_out_o",     32'(out_o),     32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_out_op",    32'(out_op),    32'd0);
    @(posedge clk); #1;

    // 2: NOR cases, zero flag on and off
    send(4'b1111, 4'b0000, 3'b010, 4'b0000);
    send(4'b0000, 4'b0110, 3'b010, 4'b1001);
    wait_drain(20);
    check("t2_op_count", 32'(op_count), 32'd2);

    // 3: back-to-back sweep of all opcodes
    do_reset(1);
    pop_cyc.delete();
    send(4'b1010, 4'b0110, 3'b000, 4'b0010);
    send(4'b1010, 4'b0110, 3'b001, 4'b1110);
    send(4'b1010, 4'b0110, 3'b010, 4'b0001);
    send(4'b1010, 4'b0110, 3'b011, 4'b1100);
    send(4'b1010, 4'b0110, 3'b100, 4'b1101);
    send(4'b1010, 4'b0110, 3'b101, 4'b0011);
    send(4'b1010, 4'b0110, 3'b110, 4'b0101);
    send(4'b1010, 4'b0110, 3'b111, 4'b0110);
    wait_drain(20);
    check("t3_pops", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) check("t3_no_bubbles", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    check("t3_op_count", 32'(op_count), 32'd8);

    // 4: backpressure fills both stages then stalls input
    out_ready = 1'b0;
    send(4'b1100, 4'b1010, 3'b000, 4'b1000);
    send(4'b1100, 4'b1010, 3'b011, 4'b0110);
    try_send(4'b0001, 4'b0010, 3'b001, 4'b0011, 4, acc);
    check("t4_third_accepted", 32'(acc), 32'd0);
    @(negedge clk);
    check("t4_in_ready",  32'(in_ready),  32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_hold_o",    32'(out_o),     32'b1000);
    check("t4_hold_op",   32'(out_op),    32'b000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(20);
    check("t4_op_count", 32'(op_count), 32'd10);

    // 5: reset with two ops in flight discards both
    out_ready = 1'b0;
    send(4'b0011, 4'b0101, 3'b001, 4'b0111);
    send(4'b0011, 4'b0101, 3'b100, 4'b1110);
    first_pops = pop_cyc.size();
    do_reset(1);
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_op_count",  32'(op_count),  32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_output", 32'(pop_cyc.size() - first_pops), 32'd0);

    // 6: counter wrap after 257 consumed results
    for (int i = 0; i < 257; i++) send(4'b0000, 4'(i), 3'b111, 4'(i));
    wait_drain(40);
    check("t6_op_count_wrap", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
